// File: rtl/serial_word_rx_if.sv
// Bundle of the serial input side and the parallel output side of serial_word_rx.
// master: the environment (line driver plus consumer); slave: the receiver.
interface serial_word_rx_if #(
  parameter int WIDTH = 8
);
  logic             s_in;
  logic             s_valid;
  logic             s_sof;
  logic [WIDTH-1:0] p_out;
  logic             p_valid;
  logic             p_ready;
  logic             busy;
  logic             overrun;
  logic             frame_err;
  logic             clr_err;

  modport master (
    output s_in, s_valid, s_sof, p_ready, clr_err,
    input  p_out, p_valid, busy, overrun, frame_err
  );

  modport slave (
    input  s_in, s_valid, s_sof, p_ready, clr_err,
    output p_out, p_valid, busy, overrun, frame_err
  );
endinterface

// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver. Frames a qualified bit stream on start-of-frame,
// assembles WIDTH-bit words and offers them on a valid/ready output register.
// A finished word sits in the shift register for one cycle and is moved into the
// output register on the following edge, so p_valid rises one cycle after the
// last bit is sampled. Overrun and framing errors are sticky until clr_err.
module serial_word_rx #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic            clk,
  input logic            reset_n,
  serial_word_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] p_out_reg, p_out_next;
  logic             p_valid_reg, p_valid_next;
  logic             overrun_reg, overrun_next;
  logic             frame_err_reg, frame_err_next;
  logic             frame_evt;
  logic             load_word, drop_word;

  // shifted: shift register advanced by one bit; fresh: new frame holding only bit 0
  logic [WIDTH-1:0] shifted, fresh;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (LSB_FIRST) begin : g_lsb
        if (gi == WIDTH-1) begin : g_top
          assign shifted[gi] = bus.s_in;
          assign fresh[gi]   = bus.s_in;
        end else begin : g_rest
          assign shifted[gi] = sr_reg[gi+1];
          assign fresh[gi]   = 1'b0;
        end
      end else begin : g_msb
        if (gi == 0) begin : g_bot
          assign shifted[gi] = bus.s_in;
          assign fresh[gi]   = bus.s_in;
        end else begin : g_rest
          assign shifted[gi] = sr_reg[gi-1];
          assign fresh[gi]   = 1'b0;
        end
      end
    end
  endgenerate

  // Framing FSM: next state, bit count, shift register and word-complete pulse
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sr_next    = sr_reg;
    done_next  = 1'b0;
    frame_evt  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.s_valid && bus.s_sof) begin
          sr_next    = fresh;
          cnt_next   = CW'(1);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.s_valid) begin
          if (bus.s_sof) begin
            // Restart: the partial word is abandoned and this bit is bit 0
            frame_evt = 1'b1;
            sr_next   = fresh;
            cnt_next  = CW'(1);
          end else begin
            sr_next = shifted;
            if (cnt_reg == CW'(WIDTH-1)) begin
              done_next  = 1'b1;
              cnt_next   = '0;
              state_next = IDLE;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output register handshake and sticky error flags (set wins over clear)
  always_comb begin
    load_word      = done_reg && (!p_valid_reg || bus.p_ready);
    drop_word      = done_reg && p_valid_reg && !bus.p_ready;
    p_out_next     = p_out_reg;
    p_valid_next   = p_valid_reg;
    if (load_word) begin
      p_out_next   = sr_reg;
      p_valid_next = 1'b1;
    end else if (p_valid_reg && bus.p_ready) begin
      p_valid_next = 1'b0;
    end
    overrun_next   = drop_word | (overrun_reg & ~bus.clr_err);
    frame_err_next = frame_evt | (frame_err_reg & ~bus.clr_err);
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      sr_reg        <= '0;
      done_reg      <= 1'b0;
      p_out_reg     <= '0;
      p_valid_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      sr_reg        <= sr_next;
      done_reg      <= done_next;
      p_out_reg     <= p_out_next;
      p_valid_reg   <= p_valid_next;
      overrun_reg   <= overrun_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign bus.p_out     = p_out_reg;
  assign bus.p_valid   = p_valid_reg;
  assign bus.busy      = (state_reg == SHIFT);
  assign bus.overrun   = overrun_reg;
  assign bus.frame_err = frame_err_reg;
endmodule
